// File: rtl/l1_miss_responder_pkg.sv
// Shared cache types for the L1 miss responder and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package l1_miss_responder_pkg;

    localparam int THREADS_PER_CORE = 4;
    localparam int CACHE_LINE_BITS  = 512;
    localparam int LINE_INDEX_BITS  = 26;

    typedef logic [LINE_INDEX_BITS-1:0]          cache_line_index_t;
    typedef logic [CACHE_LINE_BITS-1:0]          cache_line_data_t;
    typedef logic [$clog2(THREADS_PER_CORE)-1:0] l1_miss_entry_idx_t;

    // One outstanding miss: issued means the read has gone to memory and
    // the slot now waits for its data to come back in order.
    typedef struct packed {
        logic              valid;
        logic              issued;
        logic              synchronized;
        cache_line_index_t addr;
    } miss_slot_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority pointer.
// Latency: grant is combinational from request; pointer moves at the edge of update_lru.
// Backpressure: without update_lru the pointer holds, so the grant stays stable.
module rr_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int IDX_W          = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      update_lru,
    output logic [NUM_REQUESTERS-1:0] grant_oh,
    output logic [IDX_W-1:0]          grant_idx
);

    logic [IDX_W-1:0] prio_q, prio_d;
    logic             granted;
    int               cand;

    // Scan upward from the priority pointer with wrap; first requester wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        granted   = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            cand = int'(prio_q) + i;
            if (cand >= NUM_REQUESTERS) begin
                cand = cand - NUM_REQUESTERS;
            end
            if (!granted && request[cand[IDX_W-1:0]]) begin
                granted                  = 1'b1;
                grant_oh[cand[IDX_W-1:0]] = 1'b1;
                grant_idx                = cand[IDX_W-1:0];
            end
        end
    end

    // The winner becomes lowest priority once its grant is consumed.
    always_comb begin
        prio_d = prio_q;
        if (update_lru && granted) begin
            prio_d = (int'(grant_idx) == NUM_REQUESTERS - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Priority pointer register; reset favours requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// In-order FIFO of WIDTH-bit words, SIZE deep, registered storage.
// Latency: a pushed word is visible at pop_data the cycle after the push.
// Backpressure: none internally; caller must not push when full or pop when empty.
module sync_fifo #(
    parameter int WIDTH = 2,
    parameter int SIZE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CNT_W = $clog2(SIZE + 1);

    logic [WIDTH-1:0] mem_q [SIZE];
    logic [WIDTH-1:0] mem_d [SIZE];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SIZE - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(SIZE));

    // Pointer, occupancy and storage update for push/pop, both allowed together.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // State registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/l1_miss_responder.sv
// L2-side responder: tracks miss-queue line fills by entry index, reads memory, returns fills.
// Latency: ack combinational; read issued the cycle after ack; response one cycle after read data.
// Backpressure: busy slots stall req_ack; memory stalls hold the arbiter grant stable.
module l1_miss_responder
    import l1_miss_responder_pkg::*;
#(
    parameter int NUM_ENTRIES = THREADS_PER_CORE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  cache_line_index_t  req_addr,
    input  l1_miss_entry_idx_t req_idx,
    input  logic               req_synchronized,
    output logic               req_ack,
    output logic               mem_read_en,
    output cache_line_index_t  mem_read_addr,
    input  logic               mem_read_ready,
    input  logic               mem_read_data_valid,
    input  cache_line_data_t   mem_read_data,
    output logic               l2_response_valid,
    output l1_miss_entry_idx_t l2_response_idx,
    output cache_line_data_t   l2_response_data,
    output logic               l2_response_synchronized
);

    localparam int IDX_W = $bits(l1_miss_entry_idx_t);

    miss_slot_t               slot_q [NUM_ENTRIES];
    miss_slot_t               slot_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]   eligible;
    logic [NUM_ENTRIES-1:0]   grant_oh;
    l1_miss_entry_idx_t       grant_idx;
    l1_miss_entry_idx_t       head_idx;
    logic                     issue;
    logic                     ret;
    logic                     fifo_empty;
    logic                     fifo_full;

    logic                     resp_valid_q, resp_valid_d;
    l1_miss_entry_idx_t       resp_idx_q,   resp_idx_d;
    cache_line_data_t         resp_data_q,  resp_data_d;
    logic                     resp_sync_q,  resp_sync_d;

    // Slots waiting to go to memory.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            eligible[i] = slot_q[i].valid && !slot_q[i].issued;
        end
    end

    // Reset gating keeps every output low while reset is held.
    assign req_ack       = !reset && req_valid && !slot_q[req_idx].valid;
    assign mem_read_en   = !reset && (|eligible);
    assign mem_read_addr = mem_read_en ? slot_q[grant_idx].addr : '0;
    assign issue         = mem_read_en && mem_read_ready;
    assign ret           = mem_read_data_valid && !fifo_empty;

    rr_arbiter #(
        .NUM_REQUESTERS (NUM_ENTRIES),
        .IDX_W          (IDX_W)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .request    (eligible),
        .update_lru (issue),
        .grant_oh   (grant_oh),
        .grant_idx  (grant_idx)
    );

    // Memory returns data in issue order, so this FIFO maps each beat to its slot.
    sync_fifo #(
        .WIDTH (IDX_W),
        .SIZE  (NUM_ENTRIES)
    ) u_idx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (issue),
        .push_data (grant_idx),
        .pop       (ret),
        .pop_data  (head_idx),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Return frees, issue marks and accept fills; the three always hit distinct slots.
    always_comb begin
        slot_d = slot_q;
        if (ret) begin
            slot_d[head_idx].valid  = 1'b0;
            slot_d[head_idx].issued = 1'b0;
        end
        if (issue) begin
            slot_d[grant_idx].issued = 1'b1;
        end
        if (req_ack) begin
            slot_d[req_idx].valid        = 1'b1;
            slot_d[req_idx].issued       = 1'b0;
            slot_d[req_idx].synchronized = req_synchronized;
            slot_d[req_idx].addr         = req_addr;
        end
    end

    // Response is a single-cycle pulse; payload holds until the next return.
    always_comb begin
        resp_valid_d = ret;
        resp_idx_d   = resp_idx_q;
        resp_data_d  = resp_data_q;
        resp_sync_d  = resp_sync_q;
        if (ret) begin
            resp_idx_d  = head_idx;
            resp_data_d = mem_read_data;
            resp_sync_d = slot_q[head_idx].synchronized;
        end
    end

    // Slot table and response registers; reset discards all outstanding work.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                slot_q[i] <= '0;
            end
            resp_valid_q <= 1'b0;
            resp_idx_q   <= '0;
            resp_data_q  <= '0;
            resp_sync_q  <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            resp_valid_q <= resp_valid_d;
            resp_idx_q   <= resp_idx_d;
            resp_data_q  <= resp_data_d;
            resp_sync_q  <= resp_sync_d;
        end
    end

    assign l2_response_valid        = resp_valid_q;
    assign l2_response_idx          = resp_idx_q;
    assign l2_response_data         = resp_data_q;
    assign l2_response_synchronized = resp_sync_q;

`ifndef SYNTHESIS
    a_data_needs_inflight: assert property (@(posedge clk) disable iff (reset)
        mem_read_data_valid |-> !fifo_empty);
    a_popped_slot_issued: assert property (@(posedge clk) disable iff (reset)
        ret |-> (slot_q[head_idx].valid && slot_q[head_idx].issued));
    a_grant_is_eligible: assert property (@(posedge clk) disable iff (reset)
        mem_read_en |-> ((grant_oh != '0) && ((grant_oh & eligible) == grant_oh)));
    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (reset)
        issue |-> (!fifo_full || ret));
`endif

endmodule

// File: doc/l1_miss_responder.md
# l1_miss_responder

- Responder end of the L1 miss request/response protocol.
- Accepts line-fill requests from a core's load miss queue (`dequeue_*` side) and tracks them by entry index.
- Arbitrates the requests onto an in-order memory read port.
- Returns each fill to the miss queue as an `l2_response_*` tagged with the original index; those signals drive the miss queue's wake logic.
- Sits at the L2 end of the core/L2 link.

## Interface
Parameters:
- `NUM_ENTRIES`, default `THREADS_PER_CORE`: number of trackable outstanding requests; equals the miss queue's entry count.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high.
- `req_valid`  in  1: request pending; driven by the miss queue's `dequeue_ready`.
- `req_addr`  in  `cache_line_index_t`: line address.
- `req_idx`  in  `l1_miss_entry_idx_t`: miss queue entry index.
- `req_synchronized`  in  1: request is a synchronized load.
- `req_ack`  out  1: request accepted this cycle; drives the miss queue's `dequeue_ack`.
- `mem_read_en`  out  1: memory read request.
- `mem_read_addr`  out  `cache_line_index_t`: address of the memory read.
- `mem_read_ready`  in  1: memory accepts the read this cycle.
- `mem_read_data_valid`  in  1: read data returning. Data returns in issue order.
- `mem_read_data`  in  `cache_line_data_t`: returned line.
- `l2_response_valid`  out  1: response to the miss queue.
- `l2_response_idx`  out  `l1_miss_entry_idx_t`: entry index the response completes.
- `l2_response_data`  out  `cache_line_data_t`: returned line.
- `l2_response_synchronized`  out  1: echo of the original `req_synchronized`.

## Operation
Entry table: `NUM_ENTRIES` slots indexed by `req_idx`. Each slot holds {valid, issued, address, synchronized}.

Accept:
- `req_ack = req_valid && !slot[req_idx].valid`. This is combinational.
- On ack, the slot is written at the clock edge with valid=1, issued=0, and the request's address and synchronized bit.
- A request to a slot that is still valid is stalled with `req_ack` low. It is not dropped.

Issue:
- Eligible slots are those with valid && !issued.
- An rr_arbiter selects one eligible slot. `mem_read_en` is high when any slot is eligible; `mem_read_addr` is the granted slot's address.
- On `mem_read_en && mem_read_ready`:
  - set the granted slot's issued bit;
  - push its index into the in-order index FIFO (depth `NUM_ENTRIES`);
  - advance the arbiter.
- The arbiter does not advance when memory stalls, so the grant holds stable.

Return:
- On `mem_read_data_valid`, pop the FIFO head index.
- Register the response outputs: valid=1, idx=head, data=`mem_read_data`, synchronized=`slot[head].synchronized`.
- Clear `slot[head].valid` at the same edge.
- Each response has exactly one `l2_response_valid` pulse.

Simultaneous events:
- Accept, issue and return in the same cycle are permitted on distinct slots. All three take effect.
- The FIFO can never overflow, because each slot contributes at most one outstanding index.

Assertions (simulation only):
- `mem_read_data_valid` with an empty FIFO.
- Popped slot is not valid && issued.
- Granted slot is not eligible.

Reset: all slots invalid, FIFO empty, arbiter at entry 0. Every output is 0 during and after reset; this includes `req_ack`, `mem_read_en` and `l2_response_valid`.

## Timing
- An accept at edge T makes the slot eligible in cycle T+1. `mem_read_en` rises combinationally in T+1 at the earliest.
- With memory latency L (cycles from accepted read to `mem_read_data_valid`), `l2_response_valid` asserts the cycle after data valid. Minimum request-to-response latency is L+2.
- A slot freed by a response can be re-acked in the cycle the response is visible. The miss queue never re-requests that index in the same cycle.
- A reset asserted mid-operation discards all outstanding state immediately. In-flight memory data arriving after reset hits an empty FIFO, which violates the assertion. Memory must therefore be reset together with this block.

## Structure
- `cache_line_index_t`, `cache_line_data_t`, `l1_miss_entry_idx_t` and `THREADS_PER_CORE` come from the shared defines package.
- Reuse rr_arbiter (`update_lru` = issue handshake), oh_to_idx and idx_to_oh.
- The in-order index FIFO is a natural sub-module, `sync_fifo` (WIDTH = `$bits(l1_miss_entry_idx_t)`, SIZE = `NUM_ENTRIES`).

## Test plan
- Single request, idx 2, addr 0x1234, memory latency 3:
  - `req_ack` in cycle 0;
  - `mem_read_en` with addr 0x1234 in cycle 1;
  - `l2_response_valid` with idx 2 in cycle 5.
- Requests to idx 0, 1, 3 on consecutive cycles with `mem_read_ready` held low for 4 cycles:
  - `mem_read_addr` stays stable while stalled;
  - issue order is round-robin 0, 1, 3;
  - responses arrive in the same order.
- A second request to idx 1 while slot 1 is outstanding: `req_ack` stays 0 until the cycle slot 1's response is visible, then asserts.
- Same cycle: accept idx 3, issue idx 0, return idx 1. All three complete, and the next response is idx 0.
- Synchronized request, idx 2: `l2_response_synchronized` is 1 on idx 2 only.
- Reset pulsed with 3 outstanding entries: all outputs 0; after reset, a fresh request to idx 0 completes normally.
